// File: rtl/sblk_pkg.sv
// rtl/sblk_pkg.sv - shared instruction field widths and instruction struct
package sblk_pkg;

    localparam int WID_INST_TN = 3;
    localparam int WID_INST_TM = 3;
    localparam int WID_INST_TP = 2;
    localparam int WID_INST_LN = 3;
    localparam int WID_INST_LP = 3;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP
                               + WID_INST_LN + WID_INST_LP;

    typedef struct packed {
        logic [WID_INST_TN-1:0] tn;
        logic [WID_INST_TM-1:0] tm;
        logic [WID_INST_TP-1:0] tp;
        logic [WID_INST_LN-1:0] ln;
        logic [WID_INST_LP-1:0] lp;
    } inst_t;

endpackage

// File: rtl/sblk_row_disp_if.sv
// rtl/sblk_row_disp_if.sv - controller-side command and activation handshakes
interface sblk_row_disp_if #(
    parameter int N_ROW    = 4,
    parameter int WID_INST = 14,
    parameter int WID_ACT  = 16
);
    logic [WID_INST-1:0]  cmd_data;
    logic [N_ROW-1:0]     cmd_mask;
    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [2*WID_ACT-1:0] act_in;
    logic [N_ROW-1:0]     act_mask;
    logic                 act_in_vld;
    logic                 act_in_rdy;

    modport master (
        output cmd_data, cmd_mask, cmd_vld, act_in, act_mask, act_in_vld,
        input  cmd_rdy, act_in_rdy
    );

    modport slave (
        input  cmd_data, cmd_mask, cmd_vld, act_in, act_mask, act_in_vld,
        output cmd_rdy, act_in_rdy
    );
endinterface

// File: rtl/sblk_inst_fifo.sv
// rtl/sblk_inst_fifo.sv - per-row instruction FIFO with fall-through head
module sblk_inst_fifo import sblk_pkg::*; #(
    parameter int WIDTH = WID_INST,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sblk_row_disp.sv
// rtl/sblk_row_disp.sv - row dispatcher: masked instruction queues, gated issue, activation fan-out
module sblk_row_disp import sblk_pkg::*; #(
    parameter int N_ROW      = 4,
    parameter int WID_INST   = sblk_pkg::WID_INST,
    parameter int WID_ACT    = 16,
    parameter int INST_DEPTH = 4,
    parameter int ISSUE_GAP  = 2
) (
    input  logic                         clk_h,
    input  logic                         rst_n,
    sblk_row_disp_if.slave               host,
    output logic [WID_INST*N_ROW-1:0]    inst_data,
    output logic [N_ROW-1:0]             inst_en,
    input  logic [N_ROW-1:0]             status_sblk,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    input  logic [N_ROW-1:0]             act_data_in_req,
    output logic                         busy
);
    localparam int HW = $clog2(ISSUE_GAP + 1);
    localparam int LW = $clog2(INST_DEPTH) + 1;
    localparam int AW = 2 * WID_ACT;
    localparam logic [HW-1:0] GAP = HW'(ISSUE_GAP);

    logic [N_ROW-1:0] fifo_full;
    logic [N_ROW-1:0] fifo_empty;
    logic [N_ROW-1:0] fifo_nz;
    logic [N_ROW-1:0] hold_nz;
    logic [N_ROW-1:0] issue;
    logic [N_ROW-1:0] cmd_push;
    logic [N_ROW-1:0] act_load;
    logic [N_ROW-1:0] act_blk;
    logic             cmd_acc;
    logic             act_acc;

    // Multicast is all-or-nothing: any masked full FIFO stalls the whole command.
    assign host.cmd_rdy    = ~|(host.cmd_mask & fifo_full);
    assign cmd_acc         = host.cmd_vld & host.cmd_rdy;
    assign cmd_push        = {N_ROW{cmd_acc}} & host.cmd_mask;

    assign act_blk         = host.act_mask & act_data_in_vld & ~act_data_in_req;
    assign host.act_in_rdy = ~|act_blk;
    assign act_acc         = host.act_in_vld & host.act_in_rdy;
    assign act_load        = {N_ROW{act_acc}} & host.act_mask;

    assign busy = |{fifo_nz, hold_nz, act_data_in_vld, status_sblk};

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        logic [WID_INST-1:0] head;
        logic [WID_INST-1:0] inst_q;
        logic                en_q;
        logic [LW-1:0]       level;
        logic [HW-1:0]       hold_cnt;
        logic [AW-1:0]       act_q;
        logic                act_vld_q;

        sblk_inst_fifo #(
            .WIDTH (WID_INST),
            .DEPTH (INST_DEPTH)
        ) u_fifo (
            .clk       (clk_h),
            .rst_n     (rst_n),
            .push      (cmd_push[r]),
            .push_data (host.cmd_data),
            .pop       (issue[r]),
            .head      (head),
            .full      (fifo_full[r]),
            .empty     (fifo_empty[r]),
            .level     (level)
        );

        assign fifo_nz[r] = (level != '0);
        assign hold_nz[r] = (hold_cnt != '0);
        assign issue[r]   = ~fifo_empty[r] & ~hold_nz[r] & ~status_sblk[r];

        always_ff @(posedge clk_h or negedge rst_n) begin
            if (!rst_n) begin
                inst_q   <= '0;
                en_q     <= 1'b0;
                hold_cnt <= '0;
            end else begin
                en_q <= issue[r];
                if (issue[r]) begin
                    inst_q   <= head;
                    hold_cnt <= GAP;
                end else if (hold_nz[r]) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end

        // A reload in the same cycle as a drain keeps the row valid with new data.
        always_ff @(posedge clk_h or negedge rst_n) begin
            if (!rst_n) begin
                act_q     <= '0;
                act_vld_q <= 1'b0;
            end else if (act_load[r]) begin
                act_q     <= host.act_in;
                act_vld_q <= 1'b1;
            end else if (act_data_in_req[r]) begin
                act_vld_q <= 1'b0;
            end
        end

        assign inst_data[r*WID_INST +: WID_INST] = inst_q;
        assign inst_en[r]                        = en_q;
        assign act_data_in[r*AW +: AW]           = act_q;
        assign act_data_in_vld[r]                = act_vld_q;
    end

endmodule
